// File: rtl/fe_pkg.sv
// Front-end shared types: mnemonic enum (RV32I + M), decoded-entry struct, opcode constants.
// Pure declarations, no logic.
// Imported by the decoder and the decode stage.
package fe_pkg;

  typedef enum logic [5:0] {
    NULL = 6'd0,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ECALL, EBREAK,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } RV32I_INSTRUCTION_MNEMONIC_t;

  typedef struct packed {
    logic [31:0]                 pc;
    RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
    logic [4:0]                  rs1;
    logic [4:0]                  rs2;
    logic [4:0]                  rd;
    logic [31:0]                 imm;
    logic                        illegal;
  } dec_entry_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

endpackage

// File: rtl/rv32_decode_comb.sv
// Combinational decode of one RV32 instruction word into a dec_entry_t.
// Latency: zero (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
module rv32_decode_comb
  import fe_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output dec_entry_t  dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  RV32I_INSTRUCTION_MNEMONIC_t mn;
  logic        use_rs1, use_rs2, use_rd, illegal;
  logic [31:0] imm;

  // Select mnemonic and which fields the format carries; NULL marks anything not recognised
  always_comb begin
    mn      = NULL;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    imm     = 32'd0;
    case (opcode)
      OPC_LUI:   begin mn = LUI;   use_rd = 1'b1; imm = imm_u; end
      OPC_AUIPC: begin mn = AUIPC; use_rd = 1'b1; imm = imm_u; end
      OPC_JAL:   begin mn = JAL;   use_rd = 1'b1; imm = imm_j; end
      OPC_JALR: begin
        if (f3 == 3'd0) mn = JALR;
        use_rs1 = 1'b1; use_rd = 1'b1; imm = imm_i;
      end
      OPC_BRANCH: begin
        case (f3)
          3'd0: mn = BEQ;
          3'd1: mn = BNE;
          3'd4: mn = BLT;
          3'd5: mn = BGE;
          3'd6: mn = BLTU;
          3'd7: mn = BGEU;
          default: mn = NULL;
        endcase
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b;
      end
      OPC_LOAD: begin
        case (f3)
          3'd0: mn = LB;
          3'd1: mn = LH;
          3'd2: mn = LW;
          3'd4: mn = LBU;
          3'd5: mn = LHU;
          default: mn = NULL;
        endcase
        use_rs1 = 1'b1; use_rd = 1'b1; imm = imm_i;
      end
      OPC_STORE: begin
        case (f3)
          3'd0: mn = SB;
          3'd1: mn = SH;
          3'd2: mn = SW;
          default: mn = NULL;
        endcase
        use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s;
      end
      OPC_OPIMM: begin
        case (f3)
          3'd0: mn = ADDI;
          3'd2: mn = SLTI;
          3'd3: mn = SLTIU;
          3'd4: mn = XORI;
          3'd6: mn = ORI;
          3'd7: mn = ANDI;
          3'd1: mn = (f7 == F7_BASE) ? SLLI : NULL;
          3'd5: mn = (f7 == F7_BASE) ? SRLI : ((f7 == F7_ALT) ? SRAI : NULL);
          default: mn = NULL;
        endcase
        use_rs1 = 1'b1; use_rd = 1'b1; imm = imm_i;
      end
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          case (f3)
            3'd0: mn = ADD;
            3'd1: mn = SLL;
            3'd2: mn = SLT;
            3'd3: mn = SLTU;
            3'd4: mn = XOR;
            3'd5: mn = SRL;
            3'd6: mn = OR;
            default: mn = AND;
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'd0)      mn = SUB;
          else if (f3 == 3'd5) mn = SRA;
        end else if (ENABLE_M && (f7 == F7_MEXT)) begin
          case (f3)
            3'd0: mn = MUL;
            3'd1: mn = MULH;
            3'd2: mn = MULHSU;
            3'd3: mn = MULHU;
            3'd4: mn = DIV;
            3'd5: mn = DIVU;
            3'd6: mn = REM;
            default: mn = REMU;
          endcase
        end
        use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
      end
      OPC_SYSTEM: begin
        if (instr_i == 32'h0000_0073)      mn = ECALL;
        else if (instr_i == 32'h0010_0073) mn = EBREAK;
      end
      default: mn = NULL;
    endcase
  end

  // Illegal entries carry only the PC; every other field is forced to zero
  always_comb begin
    illegal        = (mn == NULL);
    dec_o.pc       = pc_i;
    dec_o.mnemonic = mn;
    dec_o.illegal  = illegal;
    dec_o.rs1      = (use_rs1 && !illegal) ? instr_i[19:15] : 5'd0;
    dec_o.rs2      = (use_rs2 && !illegal) ? instr_i[24:20] : 5'd0;
    dec_o.rd       = (use_rd  && !illegal) ? instr_i[11:7]  : 5'd0;
    dec_o.imm      = illegal ? 32'd0 : imm;
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// Registered RV32 decode stage: decoder feeding a main/skid two-entry buffer plus illegal counter.
// Latency: one cycle from acceptance to out_valid.
// Backpressure: skid entry absorbs one word when out_ready drops; in_ready falls the cycle after.
module rv32_decode_stage
  import fe_pkg::*;
#(
  parameter bit ENABLE_M  = 1'b0,
  parameter int ILL_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_instr,
  input  logic [31:0]                 in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 out_pc,
  output RV32I_INSTRUCTION_MNEMONIC_t out_mnemonic,
  output logic [4:0]                  out_rs1,
  output logic [4:0]                  out_rs2,
  output logic [4:0]                  out_rd,
  output logic [31:0]                 out_imm,
  output logic                        out_illegal,
  output logic [ILL_CNT_W-1:0]        illegal_count
);

  dec_entry_t dec;

  rv32_decode_comb #(.ENABLE_M(ENABLE_M)) u_decode (
    .instr_i (in_instr),
    .pc_i    (in_pc),
    .dec_o   (dec)
  );

  dec_entry_t           main_q, main_d, skid_q, skid_d;
  logic                 main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic [ILL_CNT_W-1:0] cnt_q, cnt_d;
  logic                 accept, consume;

  assign in_ready = !skid_vld_q;
  assign accept   = in_valid && in_ready;
  assign consume  = main_vld_q && out_ready;

  // Buffer next state: refill main from skid first, else from the decoder; park in skid when main is held
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_ready) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  // Count consumed illegal entries, holding at all-ones; a consume in a flush cycle still counts
  always_comb begin
    cnt_d = cnt_q;
    if (consume && main_q.illegal && (cnt_q != {ILL_CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(ILL_CNT_W-1){1'b0}}, 1'b1};
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid     = main_vld_q;
  assign out_pc        = main_q.pc;
  assign out_mnemonic  = main_q.mnemonic;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_rd        = main_q.rd;
  assign out_imm       = main_q.imm;
  assign out_illegal   = main_q.illegal;
  assign illegal_count = cnt_q;

endmodule
